// File: rtl/temp_i2c_poller_pkg.sv
// Shared constants for the temperature-sensor I2C poller: FSM encoding,
// quarter-bit phase names and the transaction length in bit periods.
package temp_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_ADDR  = 4'd2,
    ST_AACK  = 4'd3,
    ST_RDH   = 4'd4,
    ST_MACK  = 4'd5,
    ST_RDL   = 4'd6,
    ST_MNACK = 4'd7,
    ST_STOP  = 4'd8
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // START + addr(8) + ack + byte(8) + ack + byte(8) + nack + STOP
  localparam int TXN_BITS = 29;

endpackage

// File: rtl/temp_i2c_poller_if.sv
// Open-drain I2C pad bundle: the master pulls lines low via *_oe and
// reads the resolved SDA level back on sda_i.
interface temp_i2c_poller_if;
  logic sda_i;
  logic scl_oe;
  logic sda_oe;

  modport master (input sda_i, output scl_oe, output sda_oe);
  modport slave  (output sda_i, input scl_oe, input sda_oe);
endinterface

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit tick generator: divides clk by QTR_DIV while enabled and
// tracks the 2-bit phase within the current SCL bit period.
module i2c_qtr_tick #(
  parameter int QTR_DIV = 31
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] phase
);
  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(QTR_DIV - 1));

  // Held at zero while idle so every transaction starts on a fresh q0.
  always_ff @(posedge clk_25MHz) begin
    if (reset || !enable) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/temp_i2c_poller.sv
// Periodic I2C read of a 16-bit temperature word: START, addr+R, two data
// bytes (ACK then NACK), STOP; triggered by a poll timer or a start pulse.
module temp_i2c_poller
  import temp_i2c_pkg::*;
#(
  parameter int          QTR_DIV     = 31,
  parameter int          POLL_CYCLES = 25_000_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h4B
) (
  input  logic                      clk_25MHz,
  input  logic                      reset,
  input  logic                      start,
  temp_i2c_poller_if.master         i2c,
  output logic [15:0]               temp_data,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      ack_error
);
  localparam int PW = $clog2(POLL_CYCLES);

  state_e        state, state_n;
  logic [PW-1:0] poll_cnt;
  logic          wrap, trig;
  logic          tick, first_q, bit_end, sample, bit_scl;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg, data_hi;
  logic          scl_oe, sda_oe;

  assign busy    = (state != ST_IDLE);
  assign wrap    = (poll_cnt == PW'(POLL_CYCLES - 1));
  assign trig    = (start | wrap) & ~busy;
  assign bit_end = tick & (phase == Q3);
  assign sample  = first_q & (phase == Q2);
  assign bit_scl = (phase == Q0) | (phase == Q3);

  assign i2c.scl_oe = scl_oe;
  assign i2c.sda_oe = sda_oe;

  i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .enable    (busy),
    .tick      (tick),
    .phase     (phase)
  );

  always_ff @(posedge clk_25MHz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    unique case (state)
      ST_IDLE:  if (trig) state_n = ST_START;
      ST_START: begin
        sda_oe = phase[1];
        scl_oe = (phase == Q3);
        if (bit_end) state_n = ST_ADDR;
      end
      ST_ADDR: begin
        scl_oe = bit_scl;
        sda_oe = ~shreg[7];
        if (bit_end && bit_idx == 3'd7) state_n = ST_AACK;
      end
      ST_AACK: begin
        scl_oe = bit_scl;
        if (bit_end) state_n = ack_error ? ST_STOP : ST_RDH;
      end
      ST_RDH: begin
        scl_oe = bit_scl;
        if (bit_end && bit_idx == 3'd7) state_n = ST_MACK;
      end
      ST_MACK: begin
        scl_oe = bit_scl;
        sda_oe = 1'b1;
        if (bit_end) state_n = ST_RDL;
      end
      ST_RDL: begin
        scl_oe = bit_scl;
        if (bit_end && bit_idx == 3'd7) state_n = ST_MNACK;
      end
      ST_MNACK: begin
        scl_oe = bit_scl;
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        scl_oe = (phase == Q0);
        sda_oe = (phase != Q3);
        if (bit_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath; SDA is sampled on the first clock of q2, mid SCL-high.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      poll_cnt   <= '0;
      first_q    <= 1'b0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_hi    <= 8'h00;
      temp_data  <= 16'h0000;
      data_valid <= 1'b0;
      ack_error  <= 1'b0;
    end else begin
      poll_cnt   <= wrap ? '0 : poll_cnt + 1'b1;
      first_q    <= tick;
      data_valid <= 1'b0;
      if (trig) begin
        ack_error <= 1'b0;
        shreg     <= {DEV_ADDR, 1'b1};
        bit_idx   <= 3'd0;
      end
      unique case (state)
        ST_ADDR: if (bit_end) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_idx <= bit_idx + 3'd1;
        end
        ST_AACK: if (sample && i2c.sda_i) ack_error <= 1'b1;
        ST_RDH, ST_RDL: begin
          if (sample) shreg <= {shreg[6:0], i2c.sda_i};
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            if (state == ST_RDH && bit_idx == 3'd7) data_hi <= shreg;
          end
        end
        ST_STOP: if (bit_end && !ack_error) begin
          temp_data  <= {data_hi, shreg};
          data_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
